palette_cycler: RTL and testbench

PALETTE_CYCLER -- requirements
Module: palette_cycler

---
 rtl/palette_cycler.sv | 141 ++++++++++++++
 tb/tb_palette_cycler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_cycler.sv
// palette_cycler
//   Maps per-pixel escape iteration counts to 6-bit RRGGBB colours through a
//   16-entry rotating palette plus one in-set colour. The palette rotation
//   offset advances once every P frames (P = 1, 2, 4, 8) while cycling is enabled.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   iter_in      escape iteration count (16..31 select the in-set colour)
//   iter_valid   iter_in / blank valid this cycle
//   blank        pixel outside the visible area (forces black)
//   frame_pulse  start-of-frame strobe
//   cycle_en     enables palette rotation
//   cycle_rate   rotation period select, P = 1 << cycle_rate frames
//   cfg_wr       palette write strobe
//   cfg_addr     0..15 cycling entries, 16 in-set entry, 17..31 ignored
//   cfg_data     colour to write
//   colour_out   registered pixel colour, one cycle after iter_valid
//   colour_valid colour_out updated this cycle

module palette_cycler #(
    parameter logic [5:0] INSET_DEFAULT = 6'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] iter_in,
    input  logic       iter_valid,
    input  logic       blank,
    input  logic       frame_pulse,
    input  logic       cycle_en,
    input  logic [1:0] cycle_rate,
    input  logic       cfg_wr,
    input  logic [4:0] cfg_addr,
    input  logic [5:0] cfg_data,
    output logic [5:0] colour_out,
    output logic       colour_valid
);

    logic [5:0] pal_q [16];
    logic [5:0] pal_d [16];
    logic [5:0] inset_q, inset_d;
    logic [3:0] offset_q, offset_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [5:0] colour_out_q, colour_out_d;
    logic       colour_valid_q, colour_valid_d;

    logic [3:0] lookup_idx;
    logic [5:0] lookup_colour;
    logic [2:0] wrap_lim;

    function automatic logic [5:0] pal_reset(input logic [3:0] idx);
        logic [5:0] c;
        case (idx)
            4'd0:    c = 6'h23;
            4'd1:    c = 6'h32;
            4'd2:    c = 6'h31;
            4'd3:    c = 6'h30;
            4'd4:    c = 6'h34;
            4'd5:    c = 6'h38;
            4'd6:    c = 6'h2C;
            4'd7:    c = 6'h1C;
            4'd8:    c = 6'h0C;
            4'd9:    c = 6'h0D;
            4'd10:   c = 6'h0E;
            4'd11:   c = 6'h0B;
            4'd12:   c = 6'h07;
            4'd13:   c = 6'h03;
            4'd14:   c = 6'h02;
            default: c = 6'h01;
        endcase
        return c;
    endfunction

    always_comb begin
        pal_d          = pal_q;
        inset_d        = inset_q;
        offset_d       = offset_q;
        fcnt_d         = fcnt_q;
        colour_out_d   = colour_out_q;
        colour_valid_d = 1'b0;

        // Lookup reads registered state only, so same-cycle writes and
        // offset updates are seen from the next pixel onwards.
        lookup_idx    = iter_in[3:0] + offset_q;
        lookup_colour = iter_in[4] ? inset_q : pal_q[lookup_idx];

        if (iter_valid) begin
            colour_out_d   = blank ? '0 : lookup_colour;
            colour_valid_d = 1'b1;
        end

        case (cycle_rate)
            2'd0:    wrap_lim = 3'd0;
            2'd1:    wrap_lim = 3'd1;
            2'd2:    wrap_lim = 3'd3;
            default: wrap_lim = 3'd7;
        endcase

        // >= rather than == so a lowered rate mid-count wraps on the next pulse.
        if (frame_pulse && cycle_en) begin
            if (fcnt_q >= wrap_lim) begin
                fcnt_d   = '0;
                offset_d = offset_q + 4'd1;
            end else begin
                fcnt_d = fcnt_q + 3'd1;
            end
        end

        if (cfg_wr) begin
            if (!cfg_addr[4]) begin
                pal_d[cfg_addr[3:0]] = cfg_data;
            end else if (cfg_addr[3:0] == 4'd0) begin
                inset_d = cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                pal_q[i] <= pal_reset(i[3:0]);
            end
            inset_q        <= INSET_DEFAULT;
            offset_q       <= '0;
            fcnt_q         <= '0;
            colour_out_q   <= '0;
            colour_valid_q <= 1'b0;
        end else begin
            pal_q          <= pal_d;
            inset_q        <= inset_d;
            offset_q       <= offset_d;
            fcnt_q         <= fcnt_d;
            colour_out_q   <= colour_out_d;
            colour_valid_q <= colour_valid_d;
        end
    end

    assign colour_out   = colour_out_q;
    assign colour_valid = colour_valid_q;

endmodule

// File: tb/tb_palette_cycler.sv
// tb_palette_cycler
//   Drives palette_cycler with directed scenarios and random traffic and
//   compares every output cycle against a behavioural model of the palette.

module tb_palette_cycler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] iter_in;
    logic       iter_valid;
    logic       blank;
    logic       frame_pulse;
    logic       cycle_en;
    logic [1:0] cycle_rate;
    logic       cfg_wr;
    logic [4:0] cfg_addr;
    logic [5:0] cfg_data;
    logic [5:0] colour_out;
    logic       colour_valid;

    palette_cycler #(.INSET_DEFAULT(6'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .iter_in      (iter_in),
        .iter_valid   (iter_valid),
        .blank        (blank),
        .frame_pulse  (frame_pulse),
        .cycle_en     (cycle_en),
        .cycle_rate   (cycle_rate),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .colour_out   (colour_out),
        .colour_valid (colour_valid)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: plain integers, rotation tracked as frame counts.
    int m_pal [16];
    int m_inset;
    int m_off;
    int m_frames;
    int m_col;
    int m_val;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        int rst_tab [16] = '{'h23, 'h32, 'h31, 'h30, 'h34, 'h38, 'h2C, 'h1C,
                             'h0C, 'h0D, 'h0E, 'h0B, 'h07, 'h03, 'h02, 'h01};
        for (int i = 0; i < 16; i++) m_pal[i] = rst_tab[i];
        m_inset  = 'h00;
        m_off    = 0;
        m_frames = 0;
        m_col    = 0;
        m_val    = 0;
    endtask

    // Advance model with the currently driven inputs, clock once, compare.
    task automatic tick(input string tag);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (iter_valid) begin
                if (blank) m_col = 0;
                else if (iter_in >= 16) m_col = m_inset;
                else m_col = m_pal[(int'(iter_in) + m_off) % 16];
                m_val = 1;
            end else begin
                m_val = 0;
            end
            if (frame_pulse && cycle_en) begin
                if (m_frames >= (1 << cycle_rate) - 1) begin
                    m_frames = 0;
                    m_off = (m_off + 1) % 16;
                end else begin
                    m_frames = m_frames + 1;
                end
            end
            if (cfg_wr) begin
                if (cfg_addr < 16) m_pal[cfg_addr] = int'(cfg_data);
                else if (cfg_addr == 16) m_inset = int'(cfg_data);
            end
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_valid"}, colour_valid, m_val);
        check_eq({tag, "_colour"}, colour_out, m_col);
    endtask

    task automatic idle();
        rst_n = 1'b1; iter_valid = 1'b0; iter_in = '0; blank = 1'b0;
        frame_pulse = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic lookup(input int it, input string tag);
        idle();
        iter_valid = 1'b1;
        iter_in = 5'(it);
        tick(tag);
    endtask

    task automatic pulses(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            idle();
            frame_pulse = 1'b1;
            tick(tag);
        end
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 17; i++) lookup(i, tag);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick("reset");
        tick("reset");
    endtask

    initial begin
        int iters [5] = '{0, 5, 15, 16, 20};
        int lits  [5] = '{'h23, 'h38, 'h01, 'h00, 'h00};

        idle();
        cycle_en = 1'b0;
        cycle_rate = 2'd0;
        do_reset();

        // Basic lookup after reset
        for (int i = 0; i < 5; i++) begin
            lookup(iters[i], "basic");
            check_eq("basic_lit", colour_out, lits[i]);
        end

        // Blanked pixel, then hold
        idle();
        iter_valid = 1'b1; iter_in = 5'd7; blank = 1'b1;
        tick("blank");
        check_eq("blank_lit", colour_out, 0);
        idle();
        for (int i = 0; i < 3; i++) tick("hold");
        check_eq("hold_lit", colour_out, 0);

        // Rotation at P=2 then P=1 with offset wrap
        cycle_en = 1'b1; cycle_rate = 2'd1;
        pulses(4, "rot2");
        lookup(0, "rot2_look");
        check_eq("rot2_lit", colour_out, 'h31);
        cycle_rate = 2'd0;
        pulses(16, "rot1");
        lookup(0, "wrap_look");
        check_eq("wrap_lit", colour_out, 'h31);
        sweep("rot_sweep");

        // Write vs same-cycle lookup, ignored addresses
        do_reset();
        idle();
        cfg_wr = 1'b1; cfg_addr = 5'd3; cfg_data = 6'h3F;
        iter_valid = 1'b1; iter_in = 5'd3;
        tick("wr_same");
        check_eq("wr_old_lit", colour_out, 'h30);
        lookup(3, "wr_next");
        check_eq("wr_new_lit", colour_out, 'h3F);
        idle();
        cfg_wr = 1'b1; cfg_addr = 5'd20; cfg_data = 6'h15;
        tick("wr_ign");
        idle();
        cfg_wr = 1'b1; cfg_addr = 5'd16; cfg_data = 6'h2A;
        tick("wr_inset");
        sweep("wr_sweep");

        // Rate change mid-count, then disabled rotation
        cycle_en = 1'b1; cycle_rate = 2'd3;
        pulses(5, "rate8");
        lookup(0, "rate8_look");
        cycle_rate = 2'd1;
        pulses(1, "rate_sw");
        lookup(0, "rate_sw_look");
        pulses(1, "rate_sw2");
        lookup(0, "rate_sw2_look");
        cycle_en = 1'b0;
        pulses(5, "dis");
        lookup(0, "dis_look");
        sweep("dis_sweep");

        // Random traffic, including rare resets and coincident strobes
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            iter_valid  = 1'($urandom);
            iter_in     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom);
            blank       = ($urandom_range(0, 7) == 0);
            frame_pulse = ($urandom_range(0, 3) == 0);
            cycle_en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) cycle_rate = 2'($urandom);
            cfg_wr      = ($urandom_range(0, 7) == 0);
            cfg_addr    = 5'($urandom);
            cfg_data    = 6'($urandom);
            tick("rand");
        end

        // Reset mid-stream, with a write and pixel pending in the same cycle
        idle();
        cycle_en = 1'b1; cycle_rate = 2'd0;
        cfg_wr = 1'b1; cfg_addr = 5'd0; cfg_data = 6'h3C;
        tick("pre_rst_wr");
        pulses(3, "pre_rst_rot");
        idle();
        iter_valid = 1'b1; iter_in = 5'd1;
        tick("pre_rst_px");
        idle();
        rst_n = 1'b0; iter_valid = 1'b1; iter_in = 5'd2;
        cfg_wr = 1'b1; cfg_addr = 5'd16; cfg_data = 6'h11;
        frame_pulse = 1'b1;
        tick("rst_mid");
        check_eq("rst_mid_valid_lit", colour_valid, 0);
        check_eq("rst_mid_colour_lit", colour_out, 0);
        cycle_en = 1'b0;
        lookup(0, "post_rst");
        check_eq("post_rst_lit", colour_out, 'h23);
        lookup(16, "post_rst_inset");
        check_eq("post_rst_inset_lit", colour_out, 'h00);
        sweep("post_rst_sweep");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
